obf_insnseq: RTL

- Sequential, handshaked successor to the combinational obfuscated-instruction generator.
- Accepts one reference instruction from fetch.
- Steps a substitution position counter (ppc) internally and emits the full obfuscated sequence, one instruction per transfer, until the LUT "last" bit.
- Sits between the IF stage and the ID stage. Adds key latching per sequence, bypass mode, flush, overrun protection and a sequence statistics counter.

---
 rtl/obf_insnseq_pkg.sv | 12 +
 rtl/obf_insnseq_insngen.sv | 25 ++
 rtl/obf_insnseq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/obf_insnseq_pkg.sv
// Shared types and defaults for the sequential obfuscated-instruction generator.
`default_nettype none
package obf_insnseq_pkg;
    typedef enum logic [0:0] {
        OBF_SEQ_IDLE = 1'b0,
        OBF_SEQ_EMIT = 1'b1
    } seq_state_e;

    localparam int OBF_PPC_WIDTH = 3;
    localparam int OBF_KEY_WIDTH = 4;
endpackage
`default_nettype wire

// File: rtl/obf_insnseq_insngen.sv
// Combinational substitution LUT: maps (reference insn, position, key) to one
// obfuscated instruction plus its last/skip flags.
`default_nettype none
module obf_insngen
    import obf_insnseq_pkg::*;
#(
    parameter int PPC_WIDTH = OBF_PPC_WIDTH,
    parameter int KEY_WIDTH = OBF_KEY_WIDTH
) (
    input  logic [31:0]          ref_insn,
    input  logic [PPC_WIDTH-1:0] ppc_i,
    input  logic [KEY_WIDTH-1:0] obf_key,
    output logic [31:0]          obf_insn,
    output logic                 obf_last,
    output logic                 obf_skip
);
    // key[1:0] selects the sequence length (3 = never terminates), key[2]
    // marks the ppc 1 slot as an immediate slot.
    assign obf_insn = ref_insn
                    ^ ({{(32-PPC_WIDTH){1'b0}}, ppc_i} << 8)
                    ^ {{(32-KEY_WIDTH){1'b0}}, obf_key};
    assign obf_last = (obf_key[1:0] != 2'b11) && (ppc_i == PPC_WIDTH'(obf_key[1:0]));
    assign obf_skip = obf_key[2] && (ppc_i == PPC_WIDTH'(1));
endmodule
`default_nettype wire

// File: rtl/obf_insnseq.sv
// Handshaked sequencer between IF and ID: latches one reference instruction
// and emits its obfuscated expansion one transfer at a time.
`default_nettype none
module obf_insnseq
    import obf_insnseq_pkg::*;
#(
    parameter int PPC_WIDTH = OBF_PPC_WIDTH,
    parameter int KEY_WIDTH = OBF_KEY_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 obf_en,
    input  logic [KEY_WIDTH-1:0] obf_key,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [31:0]          in_insn,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_insn,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 out_skip,
    output logic [PPC_WIDTH-1:0] out_ppc,
    output logic                 ovr_err,
    output logic [CNT_WIDTH-1:0] emit_cnt,
    output logic [CNT_WIDTH-1:0] seq_cnt
);
    localparam logic [PPC_WIDTH-1:0] C_PPC_MAX = '1;

    seq_state_e             state_q;
    logic [31:0]            insn_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic                   en_q;
    logic                   lut_last_q;

    logic                   xfer_d, accept_d, advance_d;
    logic [31:0]            insn_d;
    logic [KEY_WIDTH-1:0]   key_d;
    logic [PPC_WIDTH-1:0]   ppc_d;
    logic [31:0]            gen_insn;
    logic                   gen_last, gen_skip;

    assign xfer_d    = out_valid & out_ready;
    assign in_ready  = (state_q == OBF_SEQ_IDLE) | (xfer_d & out_last);
    assign accept_d  = in_valid & in_ready & ~flush;
    assign advance_d = xfer_d & ~out_last & en_q & ~flush;

    // Generator sees next-cycle operands so out_insn always pairs with out_ppc.
    assign insn_d = accept_d ? in_insn : insn_q;
    assign key_d  = accept_d ? obf_key : key_q;
    assign ppc_d  = accept_d ? '0 : out_ppc + PPC_WIDTH'(1);

    obf_insngen #(
        .PPC_WIDTH (PPC_WIDTH),
        .KEY_WIDTH (KEY_WIDTH)
    ) u_insngen (
        .ref_insn (insn_d),
        .ppc_i    (ppc_d),
        .obf_key  (key_d),
        .obf_insn (gen_insn),
        .obf_last (gen_last),
        .obf_skip (gen_skip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OBF_SEQ_IDLE;
            insn_q     <= '0;
            key_q      <= '0;
            en_q       <= 1'b0;
            lut_last_q <= 1'b0;
            out_valid  <= 1'b0;
            out_insn   <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_skip   <= 1'b0;
            out_ppc    <= '0;
            ovr_err    <= 1'b0;
            emit_cnt   <= '0;
            seq_cnt    <= '0;
        end else begin
            if (xfer_d) begin
                emit_cnt <= emit_cnt + CNT_WIDTH'(1);
            end
            if (xfer_d & out_last) begin
                seq_cnt <= seq_cnt + CNT_WIDTH'(1);
                // A last that the LUT did not request was forced at max ppc.
                if (!lut_last_q) begin
                    ovr_err <= 1'b1;
                end
            end

            if (flush) begin
                state_q   <= OBF_SEQ_IDLE;
                out_valid <= 1'b0;
                out_ppc   <= '0;
            end else if (accept_d) begin
                state_q   <= OBF_SEQ_EMIT;
                insn_q    <= in_insn;
                key_q     <= obf_key;
                en_q      <= obf_en;
                out_valid <= 1'b1;
                out_first <= 1'b1;
                out_ppc   <= '0;
                if (obf_en) begin
                    out_insn   <= gen_insn;
                    lut_last_q <= gen_last;
                    out_last   <= gen_last | (ppc_d == C_PPC_MAX);
                    out_skip   <= gen_skip;
                end else begin
                    out_insn   <= in_insn;
                    lut_last_q <= 1'b1;
                    out_last   <= 1'b1;
                    out_skip   <= 1'b0;
                end
            end else if (advance_d) begin
                out_insn   <= gen_insn;
                lut_last_q <= gen_last;
                out_last   <= gen_last | (ppc_d == C_PPC_MAX);
                out_skip   <= gen_skip;
                out_ppc    <= ppc_d;
                out_first  <= 1'b0;
            end else if (xfer_d & out_last) begin
                state_q   <= OBF_SEQ_IDLE;
                out_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire
